spi_rb_initiator: RTL
=====================

Name: spi_rb_initiator

Overview:
Host-side command sequencer for the SPI register-bank protocol. It turns a parallel read/write request into chip-select-framed 16-bit word exchanges and returns the responses.
- It drives a 16-bit SPI master word engine, whose PHY handles shift timing, toward a remote SPI-to-regbank bridge.
- Used on the controller FPGA and as the active stimulus agent in system benches.

Parameters:
CSN_SETUP_CYCLES, 2, i_clk cycles from csn falling to first word start (1..255)
WORD_GAP_CYCLES, 4, idle cycles between word done and next word start; covers remote regbank read latency (1..255)
CSN_HOLD_CYCLES, 2, cycles from last word done to csn rising (1..255)
FRAME_GAP_CYCLES, 4, minimum csn-high cycles between frames (1..255)

Ports:
i_clk  in  1  main clock
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  request valid
o_req_ready  out  1  request accepted when valid&ready
i_req_write  in  1  1 = write, 0 = read burst
i_req_addr  in  8  start register address
i_req_wdata  in  16  write data (write only)
i_req_len  in  8  read burst word count; 0 treated as 1; ignored for write
o_rsp_valid  out  1  one-cycle response pulse, no backpressure
o_rsp_data  out  16  response word
o_rsp_last  out  1  final response of the request
o_busy  out  1  frame in progress (not IDLE)
o_spi_csn  out  1  chip select, active low
o_spi_tx_data  out  16  word to shift out
o_spi_tx_start  out  1  one-cycle pulse, starts one word exchange
i_spi_done  in  1  one-cycle pulse, word exchange finished
i_spi_rx_data  in  16  received word, valid with i_spi_done

Behaviour:
Reset values:
- Reset is asynchronous, active-low on i_rst_n; clock is i_clk.
- During reset, all outputs are 0 except o_spi_csn=1 and o_req_ready=1.
- State is IDLE and all counters are 0.

Request acceptance:
- o_req_ready=1 only in IDLE.
- On accept, latch write, addr, wdata and len. Len 0 becomes 1.
- Initialise the word counter: read = len+1 words, write = 2 words.

FSM states: IDLE, SETUP, START, WAIT, GAP, HOLD, FGAP.
- IDLE -> SETUP on accept. csn goes low on the next cycle.
- SETUP: count CSN_SETUP_CYCLES, then -> START.
- START:
  - Pulse o_spi_tx_start for one cycle. -> WAIT.
  - tx_data for word 0 = {8'h01 read | 8'h02 write, addr}.
  - Write word 1 = wdata. Read words 1..len = 16'h0000.
- WAIT: hold o_spi_tx_data stable until i_spi_done. On done, decrement the remaining-word count.
  - Remaining > 0 -> GAP.
  - Remaining = 0 -> HOLD.
- GAP: count WORD_GAP_CYCLES, then -> START.
- HOLD: count CSN_HOLD_CYCLES, then csn high -> FGAP.
- FGAP: count FRAME_GAP_CYCLES, then -> IDLE.

Response rules:
- The rx word of word 0 is discarded.
- Read: rx word k (1..len) = reg[addr+k-1]. Each produces o_rsp_valid the cycle after done. o_rsp_last=1 for k=len.
- Write: rx word 1 = previous register content. Emitted as one response with last=1.
- Address wraps mod 256 on the remote side. No local address arithmetic is needed.

Boundary rules:
- i_spi_done outside WAIT is ignored.
- i_req_valid during busy is not accepted; it is held off by ready=0.
- Async reset mid-frame: csn goes high immediately. Any pending response is dropped and the FSM returns to IDLE. The word engine is reset by the same reset.
- len=255 yields a 256-word frame. The word counter is 9 bits.
- Every new frame starts with csn high for at least FRAME_GAP_CYCLES, so the remote bridge always decodes from its idle state.

Decomposition:
- Package spi_rb_pkg holds:
  - command constants K_READ=8'h01, K_WRITE=8'h02, K_ACK=16'h4F4B;
  - typedef spi_rb_init_state_t.
- The package is shared with the bridge block.
- One generic delay-counter sub-module is natural: spi_rb_delay_cnt (load value, count down, done flag). It is reused for the setup, gap, hold and frame-gap counts.

Test Plan:
1. Write: req write addr=0x12 wdata=0xBEEF -> tx words 0x0212, 0xBEEF. One rsp with last=1 and data = engine rx word 1 (e.g. 0x1234). csn low for exactly 2 words.
2. Read len=3 addr=0xFE, engine returns rx 0xXXXX, 0xA0, 0xA1, 0xA2 -> tx 0x01FE, 0x0000 x3. Three rsp 0x00A0, 0x00A1, 0x00A2; last only on the third.
3. Read len=0 -> treated as 1: 2 words, one rsp with last=1.
4. Timing with defaults: csn-low to first tx_start = 2 cycles; done to next start = 4 cycles; last done to csn high = 2 cycles. The next req is not accepted for ≥4 cycles after csn high.
5. Assert reset during WAIT of word 2 of a read burst -> csn=1 and rsp_valid=0 immediately. After release, ready=1 and a new write completes normally.
6. Spurious i_spi_done in IDLE and GAP, plus i_req_valid held high while busy -> no state change, no rsp, a single request accepted only when ready.

Source files
------------

// File: rtl/spi_rb_pkg.sv
// Shared definitions for the SPI register-bank protocol (initiator and bridge).
package spi_rb_pkg;

  localparam logic [7:0]  K_READ  = 8'h01;
  localparam logic [7:0]  K_WRITE = 8'h02;
  localparam logic [15:0] K_ACK   = 16'h4F4B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_START,
    S_WAIT,
    S_GAP,
    S_HOLD,
    S_FGAP
  } spi_rb_init_state_t;

endpackage

// File: rtl/spi_rb_delay_cnt.sv
// Loadable down-counter; o_done is high during the last cycle of the loaded delay.
module spi_rb_delay_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_done
);

  logic [WIDTH-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A load of N keeps the owner in its state for exactly N cycles.
  assign o_done = (r_cnt == WIDTH'(1));

endmodule

// File: rtl/spi_rb_initiator.sv
// Host-side sequencer: frames a read burst or write as 16-bit SPI word exchanges and returns responses.
module spi_rb_initiator
  import spi_rb_pkg::*;
#(
  parameter int unsigned CSN_SETUP_CYCLES = 2,
  parameter int unsigned WORD_GAP_CYCLES  = 4,
  parameter int unsigned CSN_HOLD_CYCLES  = 2,
  parameter int unsigned FRAME_GAP_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [7:0]  i_req_addr,
  input  logic [15:0] i_req_wdata,
  input  logic [7:0]  i_req_len,
  output logic        o_rsp_valid,
  output logic [15:0] o_rsp_data,
  output logic        o_rsp_last,
  output logic        o_busy,
  output logic        o_spi_csn,
  output logic [15:0] o_spi_tx_data,
  output logic        o_spi_tx_start,
  input  logic        i_spi_done,
  input  logic [15:0] i_spi_rx_data
);

  localparam logic [7:0] L_SETUP = 8'(CSN_SETUP_CYCLES);
  localparam logic [7:0] L_GAP   = 8'(WORD_GAP_CYCLES);
  localparam logic [7:0] L_HOLD  = 8'(CSN_HOLD_CYCLES);
  localparam logic [7:0] L_FGAP  = 8'(FRAME_GAP_CYCLES);

  spi_rb_init_state_t r_state;
  logic        r_write;
  logic [7:0]  r_addr;
  logic [15:0] r_wdata;
  logic [8:0]  r_remain;
  logic        r_cmd_sent;
  logic        r_csn;
  logic [15:0] r_tx_data;
  logic        r_tx_start;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_data;
  logic        r_rsp_last;

  logic        w_dly_load;
  logic [7:0]  w_dly_val;
  logic        w_dly_done;
  logic [7:0]  w_len_eff;
  logic [15:0] w_next_word;

  assign w_len_eff   = (i_req_len == 8'd0) ? 8'd1 : i_req_len;
  assign w_next_word = !r_cmd_sent ? {(r_write ? K_WRITE : K_READ), r_addr}
                                   : (r_write ? r_wdata : 16'h0000);

  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_dly_load = 1'b0;
    w_dly_val  = '0;
    case (r_state)
      S_IDLE: if (i_req_valid) begin
        w_dly_load = 1'b1;
        w_dly_val  = L_SETUP;
      end
      S_WAIT: if (i_spi_done) begin
        w_dly_load = 1'b1;
        w_dly_val  = (r_remain == 9'd1) ? L_HOLD : L_GAP;
      end
      S_HOLD: if (w_dly_done) begin
        w_dly_load = 1'b1;
        w_dly_val  = L_FGAP;
      end
      default: ;
    endcase
  end

  spi_rb_delay_cnt #(.WIDTH(8)) u_dly (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_dly_load),
    .i_load_val (w_dly_val),
    .o_done     (w_dly_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_remain    <= '0;
      r_cmd_sent  <= 1'b0;
      r_csn       <= 1'b1;
      r_tx_data   <= '0;
      r_tx_start  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_last  <= 1'b0;
    end else begin
      r_tx_start  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      case (r_state)
        S_IDLE: if (i_req_valid) begin
          r_write    <= i_req_write;
          r_addr     <= i_req_addr;
          r_wdata    <= i_req_wdata;
          r_remain   <= i_req_write ? 9'd2 : ({1'b0, w_len_eff} + 9'd1);
          r_cmd_sent <= 1'b0;
          r_csn      <= 1'b0;
          r_state    <= S_SETUP;
        end
        S_SETUP, S_GAP: if (w_dly_done) begin
          r_tx_start <= 1'b1;
          r_tx_data  <= w_next_word;
          r_state    <= S_START;
        end
        S_START: r_state <= S_WAIT;
        S_WAIT: if (i_spi_done) begin
          r_remain   <= r_remain - 9'd1;
          r_cmd_sent <= 1'b1;
          // The reply to the command word carries no register data.
          if (r_cmd_sent) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= i_spi_rx_data;
            r_rsp_last  <= (r_remain == 9'd1);
          end
          r_state <= (r_remain == 9'd1) ? S_HOLD : S_GAP;
        end
        S_HOLD: if (w_dly_done) begin
          r_csn   <= 1'b1;
          r_state <= S_FGAP;
        end
        S_FGAP: if (w_dly_done) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready    = (r_state == S_IDLE);
  assign o_busy         = (r_state != S_IDLE);
  assign o_spi_csn      = r_csn;
  assign o_spi_tx_data  = r_tx_data;
  assign o_spi_tx_start = r_tx_start;
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_data     = r_rsp_data;
  assign o_rsp_last     = r_rsp_last;

endmodule
